// File: rtl/pool_stream_scheduler_pkg.sv
// Shared constants, lane/packet types and FSM states for the pooling stream scheduler.
package pool_stream_scheduler_pkg;

    localparam int unsigned BANKS          = 8;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned K_MAX          = 4;
    localparam int unsigned ROW_STRIDE     = 16;
    localparam int unsigned CREDITS        = 16;
    localparam int unsigned POOL_NUM       = 2;
    localparam int unsigned STAGE_STRIDE   = 8;
    localparam int unsigned TIMEOUT_CYCLES = 1024;

    localparam int unsigned COL_W  = $clog2(BANKS) + 1;
    localparam int unsigned ROWS_W = $clog2(ROW_STRIDE) + 1;
    localparam int unsigned K_W    = $clog2(K_MAX) + 1;
    localparam int unsigned ADDR_W = $clog2(K_MAX * ROW_STRIDE);

    typedef logic [DATA_W-1:0] lane_t;

    // Row packet handed to the PPU; lane 0 sits in the least significant bits.
    typedef struct packed {
        logic [BANKS-1:0]  valid;
        lane_t [BANKS-1:0] data;
    } buffer_ppu_packet_t;

    typedef enum logic [2:0] {
        StIdle,
        StStream,
        StFlush,
        StWaitFin,
        StDone
    } state_e;

    // Lanes below the configured column count carry data.
    function automatic logic [BANKS-1:0] lane_mask(input logic [COL_W-1:0] cols);
        logic [BANKS-1:0] m;
        for (int i = 0; i < BANKS; i++) begin
            m[i] = (COL_W'(i) < cols);
        end
        return m;
    endfunction

endpackage

// File: rtl/pool_stream_scheduler_if.sv
// Control, accumulator-read and PPU signals of the pooling stream scheduler.
interface pool_stream_scheduler_if;
    import pool_stream_scheduler_pkg::*;

    logic                               start;
    logic                               abort;
    logic [COL_W-1:0]                   cfg_cols;
    logic [ROWS_W-1:0]                  cfg_rows;
    logic [K_W-1:0]                     cfg_k;
    logic                               acc_rd_en;
    logic [ADDR_W-1:0]                  acc_rd_addr;
    logic [BANKS*DATA_W-1:0]            acc_rd_data;
    logic [BANKS-1:0]                   ppu_valid;
    logic [BANKS*DATA_W-1:0]            ppu_data;
    logic                               ppu_row_release;
    logic                               ppu_finish;
    logic [COL_W-1:0]                   pool_size_boundary;
    logic [POOL_NUM-1:0][COL_W-1:0]     stage_boundary;
    logic                               busy;
    logic                               done;
    logic                               err;

    // Controller / buffer / PPU side.
    modport master (
        output start, abort, cfg_cols, cfg_rows, cfg_k, acc_rd_data, ppu_row_release,
               ppu_finish,
        input  acc_rd_en, acc_rd_addr, ppu_valid, ppu_data, pool_size_boundary,
               stage_boundary, busy, done, err
    );

    // Scheduler side.
    modport slave (
        input  start, abort, cfg_cols, cfg_rows, cfg_k, acc_rd_data, ppu_row_release,
               ppu_finish,
        output acc_rd_en, acc_rd_addr, ppu_valid, ppu_data, pool_size_boundary,
               stage_boundary, busy, done, err
    );

endinterface

// File: rtl/pool_credit_counter.sv
// Saturating up/down credit counter with load-to-full and zero flag.
module pool_credit_counter #(
    parameter int unsigned MAX = 16,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    input  logic dec,
    output logic zero
);

    localparam logic [W-1:0] Full = W'(MAX);

    logic [W-1:0] count_q, count_d;

    // Next count: load wins; a simultaneous inc and dec cancel out.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = Full;
        end else if (inc && !dec) begin
            if (count_q != Full) count_d = count_q + W'(1);
        end else if (dec && !inc) begin
            if (count_q != '0) count_d = count_q - W'(1);
        end
    end

    // Count register, full after reset.
    always_ff @(posedge clk) begin
        if (rst) count_q <= Full;
        else     count_q <= count_d;
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pool_stream_scheduler.sv
// Streams accumulator rows channel-major into the max-pooling PPU under credit flow control.
module pool_stream_scheduler
    import pool_stream_scheduler_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_CYCLES
) (
    input logic                    clk,
    input logic                    rst,
    pool_stream_scheduler_if.slave bus
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0]  TmrLast = TMR_W'(TIMEOUT - 1);
    localparam logic [COL_W-1:0]  MaxCols = COL_W'(BANKS);
    localparam logic [ROWS_W-1:0] MinRows = ROWS_W'(3);
    localparam logic [ROWS_W-1:0] MaxRows = ROWS_W'(ROW_STRIDE);
    localparam logic [K_W-1:0]    MaxK    = K_W'(K_MAX);

    state_e             state_q, state_d;
    logic [COL_W-1:0]   cols_q;
    logic [ROWS_W-1:0]  rows_q;
    logic [K_W-1:0]     kcfg_q;
    logic [ROWS_W-1:0]  row_q, row_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [TMR_W-1:0]   timer_q;
    logic               rd_en;
    logic               load_cfg;
    logic               err_d, err_q;
    logic               credit_zero;
    logic               rd_pend_q;
    buffer_ppu_packet_t pkt_q, pkt_d;
    logic [COL_W-1:0]   psb_q;
    logic [POOL_NUM-1:0][COL_W-1:0] sb_q;
    logic               cfg_ok;

    assign cfg_ok = (bus.cfg_cols != '0) && (bus.cfg_cols <= MaxCols) &&
                    (bus.cfg_rows >= MinRows) && (bus.cfg_rows <= MaxRows) &&
                    (bus.cfg_k != '0) && (bus.cfg_k <= MaxK);

    // Next-state, row/group walk and read strobe.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        k_d      = k_q;
        rd_en    = 1'b0;
        load_cfg = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (cfg_ok) begin
                        load_cfg = 1'b1;
                        row_d    = '0;
                        k_d      = '0;
                        state_d  = StStream;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StStream: begin
                if (!credit_zero) begin
                    rd_en = 1'b1;
                    if (row_q == rows_q - ROWS_W'(1)) begin
                        row_d = '0;
                        if (k_q == kcfg_q - K_W'(1)) begin
                            k_d     = '0;
                            state_d = StFlush;
                        end else begin
                            k_d = k_q + K_W'(1);
                        end
                    end else begin
                        row_d = row_q + ROWS_W'(1);
                    end
                end
            end
            StFlush: state_d = StWaitFin;
            StWaitFin: begin
                if (bus.ppu_finish) begin
                    state_d = StDone;
                end else if (timer_q == TmrLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort kills the current read as well, so nothing new enters the pipe.
        if (bus.abort) begin
            state_d  = StIdle;
            row_d    = '0;
            k_d      = '0;
            rd_en    = 1'b0;
            load_cfg = 1'b0;
            err_d    = 1'b0;
        end
    end

    // FSM state, walk counters and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    // Latched tile configuration and the boundaries shown to the PPU.
    always_ff @(posedge clk) begin
        if (rst) begin
            cols_q <= '0;
            rows_q <= '0;
            kcfg_q <= '0;
            psb_q  <= '0;
            sb_q   <= '0;
        end else if (load_cfg) begin
            cols_q <= bus.cfg_cols;
            rows_q <= bus.cfg_rows;
            kcfg_q <= bus.cfg_k;
            psb_q  <= bus.cfg_cols;
            for (int i = 0; i < POOL_NUM; i++) begin
                sb_q[i] <= COL_W'(i * STAGE_STRIDE);
            end
        end
    end

    // Finish timeout, running only while waiting for the PPU.
    always_ff @(posedge clk) begin
        if (rst || state_q != StWaitFin) timer_q <= '0;
        else                             timer_q <= timer_q + TMR_W'(1);
    end

    pool_credit_counter #(
        .MAX (CREDITS)
    ) u_credits (
        .clk  (clk),
        .rst  (rst),
        .load (load_cfg || bus.abort),
        .inc  (bus.ppu_row_release),
        .dec  (rd_en),
        .zero (credit_zero)
    );

    // Masked PPU packet built from the read data returning this cycle.
    always_comb begin
        pkt_d = '0;
        if (rd_pend_q) begin
            pkt_d.valid = lane_mask(cols_q);
            for (int i = 0; i < BANKS; i++) begin
                if (pkt_d.valid[i]) pkt_d.data[i] = bus.acc_rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read-return tracking and PPU output register; abort squashes in-flight rows.
    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            rd_pend_q <= 1'b0;
            pkt_q     <= '0;
        end else begin
            rd_pend_q <= rd_en;
            pkt_q     <= pkt_d;
        end
    end

    assign bus.acc_rd_en          = rd_en;
    assign bus.acc_rd_addr        = ADDR_W'(k_q) * ADDR_W'(ROW_STRIDE) + ADDR_W'(row_q);
    assign bus.ppu_valid          = pkt_q.valid;
    assign bus.ppu_data           = pkt_q.data;
    assign bus.pool_size_boundary = psb_q;
    assign bus.stage_boundary     = sb_q;
    assign bus.busy               = (state_q != StIdle);
    assign bus.done               = (state_q == StDone);
    assign bus.err                = err_q;

endmodule

// File: tb/tb_pool_stream_scheduler.sv
// Directed bench for pool_stream_scheduler: streaming, masking, credits, errors, abort.
module tb_pool_stream_scheduler;
    import pool_stream_scheduler_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   err_cyc;
    int   done_seen;
    logic [5:0] t2_addr [6];

    pool_stream_scheduler_if bus ();

    pool_stream_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane i of word a reads back as {a, i+1}.
    function automatic logic [127:0] mem_word(input logic [5:0] a);
        logic [127:0] w;
        for (int i = 0; i < 8; i++) w[i*16 +: 16] = {2'b00, a, 8'(i + 1)};
        return w;
    endfunction

    // Accumulator buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.acc_rd_en) bus.acc_rd_data <= mem_word(bus.acc_rd_addr);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        t2_addr = '{6'd0, 6'd1, 6'd2, 6'd16, 6'd17, 6'd18};
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_cols = 4'd8;
        bus.cfg_rows = 5'd4;
        bus.cfg_k = 3'd1;
        bus.ppu_row_release = 1'b0;
        bus.ppu_finish = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Reset values.
        chk("rst_rd_en", bus.acc_rd_en, 0);
        chk("rst_addr", bus.acc_rd_addr, 0);
        chk("rst_valid", bus.ppu_valid, 0);
        chk("rst_data", bus.ppu_data, 0);
        chk("rst_psb", bus.pool_size_boundary, 0);
        chk("rst_sb", bus.stage_boundary, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);

        // Tile 1: 8 cols, 4 rows, 1 group, release every cycle; early finish ignored.
        bus.ppu_row_release = 1'b1;
        bus.start = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            step();
            if (j <= 7) begin
                chk("t1_rd_en", bus.acc_rd_en, (j <= 4) ? 1 : 0);
                chk("t1_valid", bus.ppu_valid, (j >= 3 && j <= 6) ? 8'hFF : 8'h00);
                chk("t1_done_low", bus.done, 0);
            end
            if (j <= 4) chk("t1_addr", bus.acc_rd_addr, j - 1);
            if (j == 1) begin
                bus.start = 1'b0;
                chk("t1_busy", bus.busy, 1);
                chk("t1_psb", bus.pool_size_boundary, 8);
                chk("t1_sb", bus.stage_boundary, 8'h80);
            end
            if (j == 2) bus.ppu_finish = 1'b1;
            if (j == 3) begin
                bus.ppu_finish = 1'b0;
                chk("t1_data_a0", bus.ppu_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
            end
            if (j == 6) chk("t1_data_a3", bus.ppu_data, 128'h0308_0307_0306_0305_0304_0303_0302_0301);
            if (j == 7) bus.ppu_finish = 1'b1;
            if (j == 8) begin
                bus.ppu_finish = 1'b0;
                chk("t1_done", bus.done, 1);
                chk("t1_busy_done", bus.busy, 1);
            end
            if (j == 9) begin
                chk("t1_done_end", bus.done, 0);
                chk("t1_idle", bus.busy, 0);
            end
        end

        // Tile 2: 5 cols, 3 rows, 2 groups.
        bus.cfg_cols = 4'd5;
        bus.cfg_rows = 5'd3;
        bus.cfg_k = 3'd2;
        bus.start = 1'b1;
        for (int j = 1; j <= 11; j++) begin
            step();
            if (j <= 8) begin
                chk("t2_rd_en", bus.acc_rd_en, (j <= 6) ? 1 : 0);
                chk("t2_valid", bus.ppu_valid, (j >= 3 && j <= 8) ? 8'h1F : 8'h00);
            end
            if (j <= 6) chk("t2_addr", bus.acc_rd_addr, t2_addr[j-1]);
            if (j == 1) begin
                bus.start = 1'b0;
                chk("t2_psb", bus.pool_size_boundary, 5);
            end
            if (j == 7) chk("t2_data_a17", bus.ppu_data, 128'h0000_0000_0000_1105_1104_1103_1102_1101);
            if (j == 9) bus.ppu_finish = 1'b1;
            if (j == 10) begin
                bus.ppu_finish = 1'b0;
                chk("t2_done", bus.done, 1);
            end
            if (j == 11) chk("t2_idle", bus.busy, 0);
        end

        // Tile 3: credit exhaustion, single release, release with read, then abort.
        bus.ppu_row_release = 1'b0;
        bus.cfg_cols = 4'd8;
        bus.cfg_rows = 5'd16;
        bus.cfg_k = 3'd4;
        bus.start = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            step();
            if (j == 1) bus.start = 1'b0;
            if (j <= 16) begin
                chk("t3_rd_en", bus.acc_rd_en, 1);
                chk("t3_addr", bus.acc_rd_addr, j - 1);
            end
            if (j >= 17 && j <= 20) begin
                chk("t3_stall", bus.acc_rd_en, 0);
                chk("t3_stall_addr", bus.acc_rd_addr, 16);
            end
            if (j == 20) bus.ppu_row_release = 1'b1;
            if (j == 21) begin
                chk("t3_rel_rd", bus.acc_rd_en, 1);
                chk("t3_rel_addr", bus.acc_rd_addr, 16);
                bus.ppu_row_release = 1'b0;
            end
            if (j == 22) begin
                chk("t3_rel_stall", bus.acc_rd_en, 0);
                chk("t3_rel_stall_addr", bus.acc_rd_addr, 17);
                bus.ppu_row_release = 1'b1;
            end
            if (j == 23) chk("t3_sim_rd", bus.acc_rd_en, 1);
            if (j == 24) begin
                chk("t3_sim_hold", bus.acc_rd_en, 1);
                chk("t3_sim_addr", bus.acc_rd_addr, 18);
                bus.ppu_row_release = 1'b0;
            end
            if (j == 25) begin
                chk("t3_sim_stall", bus.acc_rd_en, 0);
                chk("t3_sim_stall_addr", bus.acc_rd_addr, 19);
                bus.ppu_row_release = 1'b1;
            end
            if (j == 28) begin
                chk("t3_pre_abort_valid", bus.ppu_valid, 8'hFF);
                bus.abort = 1'b1;
            end
            if (j == 29) begin
                chk("t3_abort_busy", bus.busy, 0);
                chk("t3_abort_valid", bus.ppu_valid, 0);
                chk("t3_abort_done", bus.done, 0);
                bus.abort = 1'b0;
                bus.ppu_row_release = 1'b0;
            end
            if (j == 30) begin
                chk("t3_squash_valid", bus.ppu_valid, 0);
                chk("t3_abort_addr", bus.acc_rd_addr, 0);
                bus.start = 1'b1;
            end
        end

        // Restart after abort: from addr 0 with a full credit window.
        for (int j = 1; j <= 18; j++) begin
            step();
            if (j == 1) bus.start = 1'b0;
            if (j <= 16) begin
                chk("t4_rd_en", bus.acc_rd_en, 1);
                chk("t4_addr", bus.acc_rd_addr, j - 1);
            end
            if (j == 17) begin
                chk("t4_stall", bus.acc_rd_en, 0);
                bus.abort = 1'b1;
            end
            if (j == 18) begin
                chk("t4_abort_busy", bus.busy, 0);
                bus.abort = 1'b0;
            end
        end

        // Illegal configurations.
        bus.cfg_rows = 5'd2;
        bus.cfg_k = 3'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("bad_rows_err", bus.err, 1);
        chk("bad_rows_busy", bus.busy, 0);
        chk("bad_rows_rd", bus.acc_rd_en, 0);
        chk("bad_rows_psb", bus.pool_size_boundary, 8);
        step();
        chk("bad_err_pulse", bus.err, 0);
        bus.cfg_rows = 5'd4;
        bus.cfg_k = 3'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("bad_k_err", bus.err, 1);
        chk("bad_k_busy", bus.busy, 0);
        chk("bad_k_rd", bus.acc_rd_en, 0);
        bus.cfg_cols = 4'd9;
        bus.cfg_k = 3'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("bad_cols_err", bus.err, 1);
        chk("bad_cols_busy", bus.busy, 0);
        step();
        chk("bad_cols_err_end", bus.err, 0);

        // Timeout: 3 rows, no finish; WAIT_FIN entered 5 cycles after start.
        bus.cfg_cols = 4'd8;
        bus.cfg_rows = 5'd3;
        bus.cfg_k = 3'd1;
        bus.ppu_row_release = 1'b1;
        bus.start = 1'b1;
        err_cyc = 0;
        done_seen = 0;
        for (int j = 1; j <= 1031; j++) begin
            step();
            if (j == 1) bus.start = 1'b0;
            if (bus.err && err_cyc == 0) err_cyc = j;
            if (bus.done) done_seen++;
            if (j == 1028) chk("to_busy_before", bus.busy, 1);
            if (j == 1029) chk("to_idle", bus.busy, 0);
        end
        chk("to_err_cycle", err_cyc, 1029);
        chk("to_no_done", done_seen, 0);
        chk("to_err_end", bus.err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
